// File: rtl/layer_three_if.sv
// Layer-three classifier bus: feature map and weights in,
// winning class, its score and a completion flag out.
interface layer_three_if;
  logic [2:0]    state;
  logic [195:0]  features;
  logic [1959:0] weights;
  logic [3:0]    digit;
  logic [7:0]    best_score;
  logic          done;

  modport master (
    output state, features, weights,
    input  digit, best_score, done
  );

  modport slave (
    input  state, features, weights,
    output digit, best_score, done
  );
endinterface

// File: rtl/layer_three.sv
// Binary fully-connected output layer: XNOR-popcount score per
// class over four 49-bit chunks, keeping the first highest class.
module layer_three (
  input  logic          clk,
  input  logic          rst,
  layer_three_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    COMPARE,
    DONE
  } fsm_e;

  localparam logic [2:0] S_LAYER_3 = 3'b100;

  fsm_e        fsm_q, fsm_d;
  logic [3:0]  cls_q, cls_d;
  logic [1:0]  chunk_q, chunk_d;
  logic [7:0]  acc_q, acc_d;
  logic [3:0]  digit_q, digit_d;
  logic [7:0]  best_q, best_d;
  logic        done_q, done_d;

  logic        active;
  logic [7:0]  f_base;
  logic [10:0] w_base;
  logic [48:0] f_chunk;
  logic [48:0] w_chunk;
  logic [48:0] match;
  logic [5:0]  pc;

  assign active = (bus.state == S_LAYER_3);

  // Popcount of agreeing bits for the current class/chunk slice
  always_comb begin
    f_base  = 8'(chunk_q) * 8'd49;
    w_base  = 11'(cls_q) * 11'd196 + 11'(chunk_q) * 11'd49;
    f_chunk = bus.features[f_base +: 49];
    w_chunk = bus.weights[w_base +: 49];
    match   = ~(f_chunk ^ w_chunk);
    pc      = '0;
    for (int i = 0; i < 49; i++) begin
      pc = pc + 6'(match[i]);
    end
  end

  // Next-state, counters and result registers
  always_comb begin
    fsm_d   = fsm_q;
    cls_d   = cls_q;
    chunk_d = chunk_q;
    acc_d   = acc_q;
    digit_d = digit_q;
    best_d  = best_q;
    done_d  = done_q;
    unique case (fsm_q)
      IDLE: begin
        if (active) begin
          fsm_d   = ACCUM;
          cls_d   = '0;
          chunk_d = '0;
          acc_d   = '0;
          done_d  = 1'b0;
        end
      end
      ACCUM: begin
        if (!active) begin
          fsm_d   = IDLE;
          cls_d   = '0;
          chunk_d = '0;
          acc_d   = '0;
          done_d  = 1'b0;
        end else begin
          acc_d   = acc_q + {2'b00, pc};
          chunk_d = chunk_q + 2'd1;
          if (chunk_q == 2'd3) begin
            fsm_d = COMPARE;
          end
        end
      end
      COMPARE: begin
        if (!active) begin
          fsm_d   = IDLE;
          cls_d   = '0;
          chunk_d = '0;
          acc_d   = '0;
          done_d  = 1'b0;
        end else begin
          if (cls_q == 4'd0 || acc_q > best_q) begin
            best_d  = acc_q;
            digit_d = cls_q;
          end
          acc_d = '0;
          if (cls_q == 4'd9) begin
            fsm_d  = DONE;
            done_d = 1'b1;
          end else begin
            cls_d = cls_q + 4'd1;
            fsm_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (!active) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State and result registers, async active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cls_q   <= '0;
      chunk_q <= '0;
      acc_q   <= '0;
      digit_q <= '0;
      best_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cls_q   <= cls_d;
      chunk_q <= chunk_d;
      acc_q   <= acc_d;
      digit_q <= digit_d;
      best_q  <= best_d;
      done_q  <= done_d;
    end
  end

  assign bus.digit      = digit_q;
  assign bus.best_score = best_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_layer_three.sv
// Directed bench for layer_three: scoreboard of expected
// (digit, score) pairs checked when done rises.
module tb_layer_three;

  logic clk;
  logic rst;

  layer_three_if ifc ();

  layer_three dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [195:0]  feat;
  logic [1959:0] wts;
  logic [11:0]   exp_q[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  function automatic int score_of(input logic [195:0] f,
                                  input logic [1959:0] w,
                                  input int c);
    int s;
    s = 0;
    for (int i = 0; i < 196; i++) begin
      if (f[i] == w[c*196 + i]) s++;
    end
    return s;
  endfunction

  task automatic push_expected();
    int b;
    int d;
    int s;
    b = score_of(feat, wts, 0);
    d = 0;
    for (int c = 1; c < 10; c++) begin
      s = score_of(feat, wts, c);
      if (s > b) begin
        b = s;
        d = c;
      end
    end
    exp_q.push_back({4'(d), 8'(b)});
  endtask

  task automatic drive_data();
    ifc.features = feat;
    ifc.weights  = wts;
  endtask

  task automatic do_run(input string tag);
    int n;
    bit seen;
    logic [11:0] e;
    @(negedge clk);
    ifc.state = 3'b100;
    n = 0;
    seen = 0;
    while (n < 60 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (ifc.done === 1'b1) seen = 1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_done_edge"}, 32'(n), 32'd51);
    check({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_digit"}, 32'(ifc.digit), 32'(e[11:8]));
      check({tag, "_score"}, 32'(ifc.best_score), 32'(e[7:0]));
      @(negedge clk);
      ifc.state = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_idle_done"}, 32'(ifc.done), 32'd1);
      check({tag, "_idle_digit"}, 32'(ifc.digit), 32'(e[11:8]));
      check({tag, "_idle_score"}, 32'(ifc.best_score), 32'(e[7:0]));
    end else begin
      @(negedge clk);
      ifc.state = 3'b000;
      repeat (3) @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifc.state = 3'b000;
    feat = '0;
    wts  = '0;
    drive_data();
    #3;
    check("rst_digit", 32'(ifc.digit), 32'd0);
    check("rst_score", 32'(ifc.best_score), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    #9;
    rst = 1'b0;

    // equal scores: all zero
    feat = '0;
    wts  = '0;
    drive_data();
    push_expected();
    do_run("equal");

    // class 7 matches random features exactly
    for (int i = 0; i < 196; i++) feat[i] = 1'($urandom);
    for (int c = 0; c < 10; c++) begin
      wts[c*196 +: 196] = (c == 7) ? feat : ~feat;
    end
    drive_data();
    push_expected();
    do_run("match");

    // tie between classes 3 and 5
    feat = '0;
    wts  = '0;
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < ((c == 3 || c == 5) ? 10 : 30); k++) begin
        wts[c*196 + k*6 + (c % 3)] = 1'b1;
      end
    end
    drive_data();
    push_expected();
    do_run("tie");

    // abort at edge 20, then a full run
    for (int i = 0; i < 196; i++) feat[i] = 1'($urandom);
    for (int i = 0; i < 1960; i++) wts[i] = 1'($urandom);
    drive_data();
    @(negedge clk);
    ifc.state = 3'b100;
    repeat (19) @(posedge clk);
    #1;
    ifc.state = 3'b000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("abort_done", 32'(ifc.done), 32'd0);
    end
    push_expected();
    do_run("after_abort");

    // async reset mid-run, then a full run
    @(negedge clk);
    ifc.state = 3'b100;
    repeat (23) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    ifc.state = 3'b000;
    #1;
    check("midrst_digit", 32'(ifc.digit), 32'd0);
    check("midrst_score", 32'(ifc.best_score), 32'd0);
    check("midrst_done", 32'(ifc.done), 32'd0);
    #1;
    rst = 1'b0;
    push_expected();
    do_run("after_rst");

    // one set bit per chunk in class 9 only, features all ones
    feat = '1;
    wts  = '0;
    for (int k = 0; k < 4; k++) begin
      wts[9*196 + k*49 + 5*k + 3] = 1'b1;
    end
    drive_data();
    check("chunk_model9", 32'(score_of(feat, wts, 9)), 32'd4);
    push_expected();
    do_run("chunk");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/layer_three.md
LAYER_THREE -- requirements
Module: layer_three

Interface
REQ-001 The module SHALL have these ports; `clk` and `rst` are listed first. Columns are: name, direction, width, meaning.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `state`, input, 3: top-level phase code; this block runs while `state == 3'b100` (s_LAYER_3).
- `features`, input, 196: layer-two output map.
  - Bit index is `filter*49 + row*7 + col`, with filter 0..3, row/col 0..6.
  - Must be stable while s_LAYER_3 is active.
- `weights`, input, 1960: 10 classes × 196 binary weights.
  - Bit for class c, feature f is `weights[c*196 + f]`.
  - Must be stable while s_LAYER_3 is active.
- `digit`, output, 4: predicted class, 0..9.
- `best_score`, output, 8: winning class's XNOR-popcount score, 0..196.
- `done`, output, 1: classification complete; `digit` and `best_score` are valid.

Function
REQ-002 The FSM SHALL have four states:
- IDLE, ACCUM, COMPARE, DONE.
- Internal counters: class index `cls` (4 bits), chunk index `chunk` (2 bits).
- Internal accumulator `acc` (8 bits).

REQ-003 In IDLE, with `state == s_LAYER_3` sampled, the next edge SHALL:
- go to ACCUM;
- clear `cls`, `chunk`, `acc` and `done`.

REQ-004 Each ACCUM cycle SHALL add one chunk popcount to `acc`:
- acc += popcount(~(features[chunk*49 +: 49] ^ weights[cls*196 + chunk*49 +: 49]));
- each chunk popcount is 0..49;
- `chunk` then increments.

REQ-005 After the ACCUM cycle with `chunk == 3`, the FSM SHALL go to COMPARE with `chunk` wrapped to 0.

REQ-006 In COMPARE, the score and winner SHALL update as follows:
- If `cls == 0` or `acc > best_score` (strictly greater): `best_score <= acc`, `digit <= cls`.
- Either way, clear `acc`.
- Ties therefore resolve to the lowest class index.

REQ-007 COMPARE SHALL then take one of two transitions:
- `cls < 9`: `cls` increments and the FSM returns to ACCUM.
- `cls == 9`: the FSM goes to DONE and `done <= 1` on the same edge.

REQ-008 The arithmetic SHALL be unsigned with no saturation; the maximum score of 196 fits in 8 bits.

REQ-009 Latency: each class SHALL take exactly 5 cycles (4 ACCUM + 1 COMPARE).
- `done` rises on the 51st rising edge counted from the first edge that samples `state == s_LAYER_3` in IDLE.

REQ-010 In DONE, `digit`, `best_score` and `done` SHALL hold.
- When `state != s_LAYER_3` is sampled, the FSM returns to IDLE with all three outputs still held.

REQ-011 Outputs SHALL hold after a run and be cleared only by the next run:
- `done`, `digit` and `best_score` remain valid in IDLE after a completed run;
- they are cleared only by `rst`, or `done` by the IDLE→ACCUM transition of a new run.

REQ-012 Abort: if `state != s_LAYER_3` is sampled in ACCUM or COMPARE, the next edge SHALL:
- go to IDLE;
- clear `cls`, `chunk` and `acc`;
- keep `done` at 0.
The partial `digit` and `best_score` are then undefined-but-stable and must not be used.

REQ-013 Changes on `features` or `weights` outside s_LAYER_3 SHALL NOT affect any register.

Reset
REQ-014 While `rst` is high, asynchronously and regardless of `clk`, the block SHALL hold:
- FSM = IDLE;
- `cls`, `chunk`, `acc` = 0;
- `digit` = 0, `best_score` = 0, `done` = 0.

REQ-015 Reset mid-run SHALL abandon the run entirely.
- After `rst` deasserts, a new run starts only from IDLE per REQ-003.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Equal scores: features = 0, weights = 0, state held at s_LAYER_3.
  - Required: `done` rises on edge 51; `digit = 0`; `best_score = 196`.
- Class match: features = random R; class 7 weights = R; all other classes = ~R.
  - Required: `digit = 7`, `best_score = 196`.
- Tie: features = 0; classes 3 and 5 weights have exactly 10 ones (score 186); all other classes have 30 ones (score 166).
  - Required: `digit = 3`, `best_score = 186`.
- Abort: `state` leaves s_LAYER_3 at edge 20, then returns.
  - Required: `done` stays 0 through the abort; a full 51-edge run completes with correct results.
- Reset: `rst` pulsed asynchronously between edges mid-run.
  - Required: outputs go to 0 immediately without waiting for a clock edge; the next run completes normally.
- Per-chunk counting: one set bit per chunk in class 9 weights only, features = all ones.
  - Required: class 9 score = 4, others = 0; `digit = 9`, `best_score = 4`.
